// File: rtl/tdm_demux7.sv
// tdm_demux7: receive side of a 7-slot TDM link.
// This block aligns to the frame-start marker, steers each valid serial sample
// into a slot shadow register, and presents each complete frame in parallel.
module tdm_demux7 #(
  parameter int DW   = 1,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   din,
  input  logic            din_valid,
  input  logic            sync,
  output logic [DW-1:0]   o0,
  output logic [DW-1:0]   o1,
  output logic [DW-1:0]   o2,
  output logic [DW-1:0]   o3,
  output logic [DW-1:0]   o4,
  output logic [DW-1:0]   o5,
  output logic [DW-1:0]   o6,
  output logic            frame_valid,
  output logic [2:0]      sel,
  output logic            locked,
  output logic            sync_err,
  output logic [CNTW-1:0] frame_cnt
);

  typedef enum logic {HUNT, RUN} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      sel_reg, sel_next;
  logic            wr_en;
  logic [2:0]      wr_idx;
  logic            complete;
  logic            err;
  logic            fv_reg;
  logic            err_reg;
  logic [CNTW-1:0] cnt_reg;

  // Slot 6 never needs a shadow: it is copied straight from din on completion.
  logic [DW-1:0]   sh_reg [6];
  logic [DW-1:0]   o_reg  [7];

  // Framing FSM: decide where the current beat goes and whether it completes
  // a frame or violates alignment. A stalled beat changes nothing.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    wr_en      = 1'b0;
    wr_idx     = 3'd0;
    complete   = 1'b0;
    err        = 1'b0;
    if (din_valid) begin
      case (state_reg)
        HUNT: begin
          if (sync) begin
            wr_en      = 1'b1;
            sel_next   = 3'd1;
            state_next = RUN;
          end
        end
        RUN: begin
          if (sync) begin
            // Early sync abandons the partial frame and restarts at slot 0.
            err      = (sel_reg != 3'd0);
            wr_en    = 1'b1;
            sel_next = 3'd1;
          end else if (sel_reg == 3'd0) begin
            err        = 1'b1;
            state_next = HUNT;
            sel_next   = 3'd0;
          end else if (sel_reg == 3'd6) begin
            complete = 1'b1;
            sel_next = 3'd0;
          end else begin
            wr_en    = 1'b1;
            wr_idx   = sel_reg;
            sel_next = sel_reg + 3'd1;
          end
        end
      endcase
    end
  end

  // Control registers: state, slot pointer, strobes and the frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HUNT;
      sel_reg   <= 3'd0;
      fv_reg    <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      fv_reg    <= complete;
      err_reg   <= err;
      if (complete) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_shadow
      // Shadow slot register: captures its slot's sample while a frame builds.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_reg[gi] <= '0;
        end else if (wr_en && (wr_idx == 3'(gi))) begin
          sh_reg[gi] <= din;
        end
      end
    end

    for (gi = 0; gi < 7; gi++) begin : g_out
      // Parallel output register: loads only when a frame completes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          o_reg[gi] <= '0;
        end else if (complete) begin
          if (gi == 6) begin
            o_reg[gi] <= din;
          end else begin
            o_reg[gi] <= sh_reg[(gi < 6) ? gi : 0];
          end
        end
      end
    end
  endgenerate

  assign o0          = o_reg[0];
  assign o1          = o_reg[1];
  assign o2          = o_reg[2];
  assign o3          = o_reg[3];
  assign o4          = o_reg[4];
  assign o5          = o_reg[5];
  assign o6          = o_reg[6];
  assign frame_valid = fv_reg;
  assign sync_err    = err_reg;
  assign sel         = sel_reg;
  assign locked      = (state_reg == RUN);
  assign frame_cnt   = cnt_reg;

endmodule

// File: tb/tb_tdm_demux7.sv
// tb_tdm_demux7: scoreboard bench for the 7-slot TDM receiver.
// Expected frames are queued when their last beat is driven and checked
// by a monitor whenever frame_valid strobes.
module tb_tdm_demux7;

  localparam int DW   = 1;
  localparam int CNTW = 8;

  typedef struct packed {
    logic [6:0]      bits;
    logic [CNTW-1:0] cnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [DW-1:0]   din = '0;
  logic            din_valid = 1'b0;
  logic            sync = 1'b0;
  logic [DW-1:0]   o0, o1, o2, o3, o4, o5, o6;
  logic            frame_valid;
  logic [2:0]      sel;
  logic            locked;
  logic            sync_err;
  logic [CNTW-1:0] frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fv_cyc = -1;
  logic [CNTW-1:0] exp_cnt = '0;
  logic [6:0]      last_bits = '0;
  exp_t            sb [$];

  tdm_demux7 #(.DW(DW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6),
    .frame_valid(frame_valid), .sel(sel), .locked(locked),
    .sync_err(sync_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [6:0] outs();
    return {o6, o5, o4, o3, o2, o1, o0};
  endfunction

  // Monitor: pop and compare a frame each time the strobe is seen.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid && sync_err) begin
        vectors++;
        miscompares++;
        $display("FAIL strobe_overlap: frame_valid=1 sync_err=1, required not both");
      end
      if (frame_valid) begin
        exp_t e;
        fv_cyc = cyc;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_frame: frame_valid=1 with no frame expected");
        end else begin
          e = sb.pop_front();
          if (outs() !== e.bits || frame_cnt !== e.cnt) begin
            miscompares++;
            $display("FAIL frame: got o=%b cnt=%0d, required o=%b cnt=%0d",
                     outs(), frame_cnt, e.bits, e.cnt);
          end
          last_bits = e.bits;
        end
      end
    end
  end

  // One valid beat; returns at the next negedge with its effect visible.
  task automatic beat(input logic d, input logic s);
    din = d; sync = s; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Full frame of 7 beats; expectation queued as the last beat is driven.
  task automatic send_frame(input logic [6:0] bits);
    for (int k = 0; k < 7; k++) begin
      if (k == 6) begin
        exp_cnt = exp_cnt + 1'b1;
        sb.push_back('{bits: bits, cnt: exp_cnt});
      end
      beat(bits[k], k == 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    vectors++;
    if (outs() !== 7'd0 || frame_valid !== 1'b0 || sel !== 3'd0 ||
        locked !== 1'b0 || sync_err !== 1'b0 || frame_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_state: o=%b fv=%b sel=%0d lk=%b err=%b cnt=%0d, required all 0",
               outs(), frame_valid, sel, locked, sync_err, frame_cnt);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_basic_frame();
    int start;
    start = cyc;
    send_frame(7'b1111011);
    vectors++;
    if (frame_valid !== 1'b1 || cyc - start !== 7) begin
      miscompares++;
      $display("FAIL basic_latency: fv=%b after %0d cycles, required 1 after 7",
               frame_valid, cyc - start);
    end
    vectors++;
    if (sel !== 3'd0 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_state: sel=%0d locked=%b, required sel=0 locked=1", sel, locked);
    end
    idle(1);
    vectors++;
    if (frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL strobe_width: fv=%b one cycle later, required 0", frame_valid);
    end
  endtask

  task automatic test_stall();
    logic [6:0] bits;
    int start;
    bits = 7'b1111011;
    start = cyc;
    for (int k = 0; k < 4; k++) beat(bits[k], k == 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      vectors++;
      if (sel !== 3'd4 || frame_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold: sel=%0d fv=%b, required sel=4 fv=0", sel, frame_valid);
      end
    end
    for (int k = 4; k < 7; k++) begin
      if (k == 6) begin
        exp_cnt = exp_cnt + 1'b1;
        sb.push_back('{bits: bits, cnt: exp_cnt});
      end
      beat(bits[k], 1'b0);
    end
    vectors++;
    if (frame_valid !== 1'b1 || cyc - start !== 10) begin
      miscompares++;
      $display("FAIL stall_latency: fv=%b after %0d cycles, required 1 after 10",
               frame_valid, cyc - start);
    end
  endtask

  task automatic test_hunt_discard();
    // Drop back to HUNT via a sync=0 beat at slot 0 first.
    beat(1'b1, 1'b0);
    vectors++;
    if (sync_err !== 1'b1 || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL lost_align: err=%b locked=%b, required err=1 locked=0", sync_err, locked);
    end
    for (int i = 0; i < 5; i++) begin
      beat(1'($urandom_range(0, 1)), 1'b0);
      vectors++;
      if (sync_err !== 1'b0 || sel !== 3'd0 || locked !== 1'b0 ||
          frame_valid !== 1'b0 || outs() !== last_bits) begin
        miscompares++;
        $display("FAIL hunt_discard: err=%b sel=%0d lk=%b fv=%b o=%b, required 0 0 0 0 o=%b",
                 sync_err, sel, locked, frame_valid, outs(), last_bits);
      end
    end
    send_frame(7'b0101010);
    vectors++;
    if (outs() !== 7'b0101010 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL hunt_relock: o=%b lk=%b, required o=0101010 lk=1", outs(), locked);
    end
  endtask

  task automatic test_early_sync();
    logic [6:0] bits;
    logic [CNTW-1:0] cnt_before;
    cnt_before = frame_cnt;
    for (int k = 0; k < 4; k++) beat(1'b1, k == 0);
    vectors++;
    if (sel !== 3'd4) begin
      miscompares++;
      $display("FAIL early_pre: sel=%0d, required 4", sel);
    end
    bits = 7'b1001101;
    beat(bits[0], 1'b1);
    vectors++;
    if (sync_err !== 1'b1 || sel !== 3'd1 || frame_cnt !== cnt_before ||
        outs() !== last_bits || frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_sync: err=%b sel=%0d cnt=%0d o=%b, required err=1 sel=1 cnt=%0d o=%b",
               sync_err, sel, frame_cnt, outs(), cnt_before, last_bits);
    end
    for (int k = 1; k < 7; k++) begin
      if (k == 6) begin
        exp_cnt = exp_cnt + 1'b1;
        sb.push_back('{bits: bits, cnt: exp_cnt});
      end
      beat(bits[k], 1'b0);
    end
    vectors++;
    if (frame_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL early_complete: fv=%b, required 1", frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) send_frame(7'($urandom));
    vectors++;
    if (frame_valid !== 1'b1 || sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back: fv=%b err=%b, required fv=1 err=0", frame_valid, sync_err);
    end
  endtask

  task automatic test_async_reset_wrap();
    for (int k = 0; k < 3; k++) beat(1'b1, k == 0);
    vectors++;
    if (sel !== 3'd3) begin
      miscompares++;
      $display("FAIL rst_pre: sel=%0d, required 3", sel);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (outs() !== 7'd0 || sel !== 3'd0 || locked !== 1'b0 ||
        frame_cnt !== '0 || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: o=%b sel=%0d lk=%b cnt=%0d, required all 0",
               outs(), sel, locked, frame_cnt);
    end
    exp_cnt = '0;
    last_bits = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    for (int f = 0; f < 256; f++) send_frame(7'($urandom));
    vectors++;
    if (frame_cnt !== '0) begin
      miscompares++;
      $display("FAIL cnt_wrap: frame_cnt=%0d, required 0", frame_cnt);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_stall();
    test_hunt_discard();
    test_early_sync();
    test_back_to_back();
    test_async_reset_wrap();
    idle(3);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d frames never seen, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
